// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch unit bus: imem port, decode handshake, next-PC loop, status
interface ifu_fetch_if;
  logic [31:2] npc;
  logic [31:2] pc;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:2] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        stall;
  logic [31:0] fetch_cnt;
  logic        fetch_err;

  modport master (
    input  npc, imem_ack, imem_rdata, ir_ready, stall,
    output pc, imem_req, ir, ir_pc, ir_valid, fetch_cnt, fetch_err
  );

  modport slave (
    output npc, imem_ack, imem_rdata, ir_ready, stall,
    input  pc, imem_req, ir, ir_pc, ir_valid, fetch_cnt, fetch_err
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC register, imem fetch with timeout, decode handoff
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 16
) (
  input logic       clk,
  input logic       rst,
  ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

  // Last wait count at which a missing ack turns into an error.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:2] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:2] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        fetch_err_q, fetch_err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    fetch_err_d = fetch_err_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // An ack on the would-be timeout cycle still completes the fetch.
        if (bus.imem_ack) begin
          ir_d       = bus.imem_rdata;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = HOLD;
        end else if (wait_cnt_q == WAIT_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (bus.ir_ready && !bus.stall) begin
          pc_d        = bus.npc;
          ir_valid_d  = 1'b0;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = FETCH;
        end
      end
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC[31:2];
      ir_q        <= 32'd0;
      ir_pc_q     <= 30'd0;
      ir_valid_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
      fetch_err_q <= 1'b0;
      wait_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      fetch_err_q <= fetch_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.imem_req  = (state_q == FETCH);
  assign bus.ir        = ir_q;
  assign bus.ir_pc     = ir_pc_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized bench for ifu_fetch with a transaction-level reference model
module tb_ifu_fetch;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(32'h0000_3000), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: 0 = about to fetch, 1 = waiting on memory, 2 = holding for decode, 3 = dead.
  int          m_phase = 0;
  int          m_waited = 0;
  logic [31:2] m_pc = 30'h0C00;
  logic [31:0] m_ir = 32'd0;
  logic [31:2] m_ir_pc = 30'd0;
  logic        m_valid = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  logic        m_err = 1'b0;
  logic        m_load = 1'b0;
  logic        chk_en = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      if (m_load) begin
        m_cnt  = 32'hFFFF_FFFF;
        m_load = 1'b0;
      end
      if (rst) begin
        m_phase = 0; m_waited = 0; m_pc = 30'h0C00; m_ir = 32'd0;
        m_ir_pc = 30'd0; m_valid = 1'b0; m_cnt = 32'd0; m_err = 1'b0;
      end else if (m_phase == 0) begin
        m_phase = 1; m_waited = 0;
      end else if (m_phase == 1) begin
        if (bus.imem_ack) begin
          m_ir = bus.imem_rdata; m_ir_pc = m_pc; m_valid = 1'b1; m_phase = 2;
        end else begin
          m_waited++;
          if (m_waited == TO) begin
            m_err = 1'b1; m_phase = 3;
          end
        end
      end else if (m_phase == 2) begin
        if (bus.ir_ready && !bus.stall) begin
          m_pc = bus.npc; m_valid = 1'b0; m_cnt = m_cnt + 1; m_phase = 1; m_waited = 0;
        end
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("pc", 32'(bus.pc), 32'(m_pc));
        chk("imem_req", 32'(bus.imem_req), 32'(m_phase == 1));
        chk("ir_valid", 32'(bus.ir_valid), 32'(m_valid));
        chk("ir", bus.ir, m_ir);
        chk("ir_pc", 32'(bus.ir_pc), 32'(m_ir_pc));
        chk("fetch_cnt", bus.fetch_cnt, m_cnt);
        chk("fetch_err", 32'(bus.fetch_err), 32'(m_err));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.ir_ready = 1'b0;
    bus.stall = 1'b0; bus.npc = 30'd0;
    fork
      model_loop();
      compare_loop();
    join_none

    // Reset and first fetch
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_pc", 32'(bus.pc), 32'h0000_0C00);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_cnt", bus.fetch_cnt, 32'd0);
    rst = 1'b0;
    tick();
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_pc", 32'(bus.pc), 32'h0000_0C00);

    // Zero-wait stream
    bus.imem_ack = 1'b1; bus.ir_ready = 1'b1; bus.imem_rdata = 32'h2008_0005;
    for (int i = 0; i < 6; i++) begin
      bus.npc = m_pc + 30'd1;
      tick();
      if (i % 2 == 0) begin
        chk("stream_ir_pc", 32'(bus.ir_pc), 32'h0000_0C00 + 32'(i / 2));
        chk("stream_valid", 32'(bus.ir_valid), 32'd1);
        chk("stream_ir", bus.ir, 32'h2008_0005);
      end
    end
    chk("stream_cnt", bus.fetch_cnt, 32'd3);

    // Stall and backpressure in HOLD
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    tick();
    bus.imem_ack = 1'b0; bus.stall = 1'b1; bus.ir_ready = 1'b1; bus.npc = 30'h0000_0999;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        bus.stall = 1'b0; bus.ir_ready = 1'b0;
      end
      tick();
      chk("hold_pc", 32'(bus.pc), 32'h0000_0C03);
      chk("hold_ir", bus.ir, 32'h1234_5678);
      chk("hold_cnt", bus.fetch_cnt, 32'd3);
    end
    bus.ir_ready = 1'b1; bus.npc = m_pc + 30'd1;
    tick();
    chk("accept_cnt", bus.fetch_cnt, 32'd4);
    chk("accept_pc", 32'(bus.pc), 32'h0000_0C04);

    // Jump through npc
    bus.imem_ack = 1'b1; bus.ir_ready = 1'b0;
    tick();
    bus.imem_ack = 1'b0; bus.ir_ready = 1'b1; bus.npc = 30'h0000_0040;
    tick();
    chk("jump_pc", 32'(bus.pc), 32'h0000_0040);
    chk("jump_req", 32'(bus.imem_req), 32'd1);
    bus.imem_ack = 1'b1; bus.ir_ready = 1'b0;
    tick();
    chk("jump_ir_pc", 32'(bus.ir_pc), 32'h0000_0040);
    bus.imem_ack = 1'b0; bus.ir_ready = 1'b1; bus.npc = m_pc + 30'd1;
    tick();
    bus.ir_ready = 1'b0;

    // Timeout: no ack for TIMEOUT cycles after req rose
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k < TO) chk("to_err_low", 32'(bus.fetch_err), 32'd0);
    end
    chk("to_err_high", 32'(bus.fetch_err), 32'd1);
    chk("to_req_low", 32'(bus.imem_req), 32'd0);
    rst = 1'b1;
    tick();
    chk("to_rst_clear", 32'(bus.fetch_err), 32'd0);
    rst = 1'b0;
    tick();
    repeat (TO - 1) tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_0001;
    tick();
    chk("late_ack_err", 32'(bus.fetch_err), 32'd0);
    chk("late_ack_valid", 32'(bus.ir_valid), 32'd1);
    chk("late_ack_ir_pc", 32'(bus.ir_pc), 32'h0000_0C00);

    // Counter wrap
    bus.imem_ack = 1'b0; bus.stall = 1'b1; bus.ir_ready = 1'b1;
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    m_load = 1'b1;
    tick();
    release dut.fetch_cnt_q;
    chk("preload_cnt", bus.fetch_cnt, 32'hFFFF_FFFF);
    bus.stall = 1'b0; bus.npc = m_pc + 30'd1;
    tick();
    chk("wrap_cnt", bus.fetch_cnt, 32'd0);

    // Reset mid-fetch with a coincident ack
    bus.ir_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1; bus.imem_ack = 1'b1;
    tick();
    chk("rstack_valid", 32'(bus.ir_valid), 32'd0);
    chk("rstack_req", 32'(bus.imem_req), 32'd0);
    chk("rstack_pc", 32'(bus.pc), 32'h0000_0C00);
    rst = 1'b0; bus.imem_ack = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      automatic bit drought = (c >= 700 && c < 720) || (c >= 1500 && c < 1530);
      rst = ($urandom_range(0, 199) == 0);
      bus.imem_ack = !drought && ($urandom_range(0, 2) == 0);
      bus.imem_rdata = $urandom;
      bus.ir_ready = ($urandom_range(0, 3) != 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.npc = ($urandom_range(0, 3) == 0) ? 30'($urandom) : m_pc + 30'd1;
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit holding the program counter. It issues word-aligned fetches to instruction memory and presents the fetched instruction to decode under a valid/ready handshake. It feeds `pc` to the next-PC block and loads that block's `npc` result once decode accepts the current instruction. The unit also counts accepted instructions and flags a sticky error when memory fails to answer.

## Interface
- `RESET_PC`, 32'h0000_3000, byte address loaded on reset; bits [1:0] ignored.
- `TIMEOUT`, 16, max cycles in FETCH without `imem_ack` before error; legal range 2..255.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `npc` in [31:2]: next word address from next-PC logic, computed combinationally from `pc`.
- `pc` out [31:2]: current word address, drives next-PC logic and instruction memory address.
- `imem_req` out 1: fetch request for word `pc`.
- `imem_ack` in 1: `imem_rdata` valid this cycle; only meaningful while `imem_req`=1.
- `imem_rdata` in 32: instruction word.
- `ir` out 32: fetched instruction to decode.
- `ir_pc` out [31:2]: word address of `ir`.
- `ir_valid` out 1: `ir`/`ir_pc` valid.
- `ir_ready` in 1: decode accepts `ir`.
- `stall` in 1: hazard hold; blocks acceptance.
- `fetch_cnt` out 32: number of accepted instructions, wraps.
- `fetch_err` out 1: sticky fetch timeout.

## Operation
- States: IDLE, FETCH, HOLD, ERR. Registered state; `imem_req` = (state==FETCH); every other output is a register.
- IDLE: entered on reset; unconditionally goes to FETCH next cycle.
- FETCH: `imem_req`=1. `wait_cnt` increments each cycle without ack.
  - `imem_ack`=1: `ir`<=`imem_rdata`, `ir_pc`<=`pc`, `ir_valid`<=1, `wait_cnt`<=0, go HOLD.
  - No ack and `wait_cnt`==TIMEOUT-1: `fetch_err`<=1, go ERR.
  - An ack in the same cycle the timeout would fire wins; no error is raised.
- HOLD: `ir_valid`=1, `ir`/`ir_pc` stable, `pc` stable so `npc` may be resolved from decode of `ir`.
  - `ir_ready`=1 and `stall`=0: `pc`<=`npc`, `ir_valid`<=0, `fetch_cnt`<=`fetch_cnt`+1 (mod 2^32), go FETCH.
  - `stall`=1 overrides `ir_ready`: stay, no register changes.
- ERR: `imem_req`=0, `ir_valid`=0, `fetch_err`=1; exits only via `rst`.
- `pc` changes only on acceptance in HOLD, or on reset. `npc` is sampled only at that edge.
- Addresses wrap naturally in 30 bits; no alignment checks are needed (word addressing).

## Timing
- Reset values (cycle after `rst` sampled high): state=IDLE, `pc`=RESET_PC[31:2], `ir`=0, `ir_pc`=0, `ir_valid`=0, `fetch_cnt`=0, `fetch_err`=0, `wait_cnt`=0, `imem_req`=0.
- First `imem_req` is asserted 1 cycle after `rst` deasserts (IDLE->FETCH).
- `imem_ack` may arrive in the first FETCH cycle. Minimum throughput is 2 cycles/instruction (FETCH, HOLD).
- `ir_valid` rises the cycle after the ack edge. `pc` holds the `npc` value the cycle after the acceptance edge.
- Timeout: with req first high in cycle t and no ack, `fetch_err`=1 from cycle t+TIMEOUT.
- Reset mid-operation, in any state: pending fetch is abandoned, an ack in the reset cycle is ignored, all registers take reset values, and a sticky error is cleared.

## Test plan
- Reset/first fetch: hold `rst` 2 cycles, then release -> `pc`=0x0C00 (byte 0x3000), `imem_req`=1 one cycle after release, `fetch_cnt`=0.
- Zero-wait stream: ack in every FETCH cycle, `ir_ready`=1, `npc`=`pc`+1, rdata=0x2008_0005 -> `ir_valid` every other cycle, `ir_pc` 0x0C00, 0x0C01, 0x0C02; `fetch_cnt`=3 after 6 cycles.
- Stall/backpressure: in HOLD, `stall`=1 for 3 cycles with `ir_ready`=1, then `ir_ready`=0 for 2 cycles -> `ir`/`pc` unchanged, `fetch_cnt` unchanged; acceptance occurs on the first cycle with ready=1, stall=0.
- Jump via npc: in HOLD, drive `npc`=0x0000_0040 and accept -> next `imem_req` has `pc`=0x40, `ir_pc`=0x40 after ack.
- Timeout/boundary: TIMEOUT=16, no ack -> `fetch_err`=1 exactly 16 cycles after req rose, `imem_req`=0. Repeat with ack in cycle 16 (wait_cnt=15) -> no error, HOLD entered. `rst` clears the error.
- Counter wrap/reset mid-fetch: preload `fetch_cnt`=0xFFFF_FFFF via 2^32-1 forced accepts (or force), then accept -> 0. Assert `rst` while waiting for an ack, with ack on the same edge -> `ir_valid` stays 0 and state is IDLE.
